// File: rtl/lighting_pkg.sv
// Shared definitions for the smart lighting controller front end.
//   filt_state_t    : state of a stable (debounce / glitch) filter
//   DEF_*           : default filter thresholds, in clock cycles
//   max2()          : helper used to size filter counters
package lighting_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } filt_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500;
    localparam int DEF_PIR_ON_CYCLES   = 3;
    localparam int DEF_PIR_OFF_CYCLES  = 3;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/stable_filter.sv
// Stable filter: the output level follows sync_in only after sync_in has
// disagreed with the current level for a full threshold of consecutive
// cycles. Shorter disagreements are dropped without any output effect.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   sync_in : already-synchronized input
//   level   : filtered level (registered)
//   rise    : one-cycle pulse in the first cycle level reads 1
//   fall    : one-cycle pulse in the first cycle level reads 0
module stable_filter
    import lighting_pkg::*;
#(
    parameter int ON_CYCLES  = DEF_PIR_ON_CYCLES,   // threshold while level=0
    parameter int OFF_CYCLES = DEF_PIR_OFF_CYCLES   // threshold while level=1
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(max2(ON_CYCLES, OFF_CYCLES) + 1);
    localparam logic [CNT_W-1:0] ON_T  = CNT_W'(ON_CYCLES);
    localparam logic [CNT_W-1:0] OFF_T = CNT_W'(OFF_CYCLES);

    filt_state_t      state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc, thr;
    logic             level_d, rise_d, fall_d, flip;

    // Threshold depends on which direction we are trying to move.
    assign thr     = level ? OFF_T : ON_T;
    // cnt stays below thr, so the increment cannot overflow CNT_W.
    assign cnt_inc = cnt + CNT_W'(1);
    assign flip    = (cnt_inc == thr);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        level_d = level;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state)
            STABLE: begin
                if (sync_in != level) begin
                    // A threshold of 1 resolves on the very first mismatch.
                    if (flip) begin
                        level_d = ~level;
                        rise_d  = ~level;
                        fall_d  = level;
                        cnt_d   = '0;
                    end else begin
                        state_d = PENDING;
                        cnt_d   = cnt_inc;
                    end
                end
            end
            PENDING: begin
                if (sync_in == level) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (flip) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    level_d = ~level;
                    rise_d  = ~level;
                    fall_d  = level;
                end else begin
                    cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= STABLE;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            level <= level_d;
            rise  <= rise_d;
            fall  <= fall_d;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Input conditioner for the lighting controller: synchronizes the raw push
// button and PIR sensor, debounces the button and glitch-filters the PIR.
//   clk           : system clock
//   rst           : asynchronous active-low reset
//   push_button   : raw, bouncy button (asynchronous)
//   infravermelho : raw PIR sensor (asynchronous)
//   btn_level     : debounced button level
//   btn_press     : one-cycle pulse on debounced rising edge
//   btn_release   : one-cycle pulse on debounced falling edge
//   motion        : filtered motion level
//   motion_rise   : one-cycle pulse when motion goes 0->1
module input_conditioner
    import lighting_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PIR_ON_CYCLES   = DEF_PIR_ON_CYCLES,
    parameter int PIR_OFF_CYCLES  = DEF_PIR_OFF_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic push_button,
    input  logic infravermelho,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic motion,
    output logic motion_rise
);

    localparam int NUM_CH = 2;
    localparam int CH_BTN = 0;
    localparam int CH_PIR = 1;

    logic [NUM_CH-1:0] raw, meta, sync;
    logic              pir_fall_unused;

    assign raw[CH_BTN] = push_button;
    assign raw[CH_PIR] = infravermelho;

    // Two-flop synchronizer per channel; meta may go metastable, sync is clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw;
            sync <= meta;
        end
    end

    stable_filter #(
        .ON_CYCLES  (DEBOUNCE_CYCLES),
        .OFF_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_filt (
        .clk     (clk),
        .rst     (rst),
        .sync_in (sync[CH_BTN]),
        .level   (btn_level),
        .rise    (btn_press),
        .fall    (btn_release)
    );

    // The controller has no use for the motion falling edge.
    stable_filter #(
        .ON_CYCLES  (PIR_ON_CYCLES),
        .OFF_CYCLES (PIR_OFF_CYCLES)
    ) u_pir_filt (
        .clk     (clk),
        .rst     (rst),
        .sync_in (sync[CH_PIR]),
        .level   (motion),
        .rise    (motion_rise),
        .fall    (pir_fall_unused)
    );

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner (DEBOUNCE=8, PIR on/off=3).
// Stimulus pushes the expected pulse events; a negedge monitor pops one
// entry whenever any pulse output is high and checks cycle, kind and levels.
module tb_input_conditioner;

    localparam logic [2:0] BP = 3'b100;  // {btn_press, btn_release, motion_rise}
    localparam logic [2:0] BR = 3'b010;
    localparam logic [2:0] MR = 3'b001;

    typedef struct {
        int         cyc;
        logic [2:0] pulses;
        logic       bl;
        logic       mo;
    } exp_t;

    logic clk = 1'b0;
    logic rst, push_button, infravermelho;
    logic btn_level, btn_press, btn_release, motion, motion_rise;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    input_conditioner #(
        .DEBOUNCE_CYCLES (8),
        .PIR_ON_CYCLES   (3),
        .PIR_OFF_CYCLES  (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push_button   (push_button),
        .infravermelho (infravermelho),
        .btn_level     (btn_level),
        .btn_press     (btn_press),
        .btn_release   (btn_release),
        .motion        (motion),
        .motion_rise   (motion_rise)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input logic [2:0] p, input logic bl, input logic mo);
        exp_t e;
        e.cyc = c; e.pulses = p; e.bl = bl; e.mo = mo;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [2:0] p;
        exp_t       e;
        p = {btn_press, btn_release, motion_rise};
        if (p != 3'b000) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got %b expected none at cycle %0d", p, cyc);
            end else begin
                e = sb.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("pulse_kind", int'(p), int'(e.pulses));
                chk("pulse_btn_level", int'(btn_level), int'(e.bl));
                chk("pulse_motion", int'(motion), int'(e.mo));
            end
        end
    end

    initial begin
        int c;
        rst = 1'b1; push_button = 1'b1; infravermelho = 1'b1;
        #1 rst = 1'b0;
        tick(4);
        // Held in reset with inputs high: everything low.
        chk("rst_btn_level", int'(btn_level), 0);
        chk("rst_btn_press", int'(btn_press), 0);
        chk("rst_btn_release", int'(btn_release), 0);
        chk("rst_motion", int'(motion), 0);
        chk("rst_motion_rise", int'(motion_rise), 0);

        // 1: release reset, inputs held high.
        rst = 1'b1; c = cyc;
        push(c + 5, MR, 1'b0, 1'b1);
        push(c + 10, BP, 1'b1, 1'b1);
        tick(15);

        // 3b: 7-cycle low glitch is discarded.
        push_button = 1'b0; tick(7); push_button = 1'b1; tick(15);
        chk("glitch_btn_level", int'(btn_level), 1);

        // 3a: real release.
        push_button = 1'b0; c = cyc;
        push(c + 10, BR, 1'b0, 1'b1);
        tick(15);

        // 2: bounce every 3 cycles, ending high.
        for (int k = 0; k <= 10; k++) begin
            push_button = (k % 2 == 0);
            if (k < 10) tick(3);
        end
        c = cyc;
        push(c + 10, BP, 1'b1, 1'b1);
        tick(15);

        // 4: PIR low (no fall pulse), 2-cycle blip, 6-cycle pulse.
        infravermelho = 1'b0; c = cyc;
        tick(4); chk("pir_off_hold", int'(motion), 1);
        tick(1); chk("pir_off_edge", int'(motion), 0);
        tick(5);
        infravermelho = 1'b1; tick(2); infravermelho = 1'b0; tick(10);
        chk("pir_blip_rejected", int'(motion), 0);
        infravermelho = 1'b1; c = cyc;
        push(c + 5, MR, 1'b1, 1'b1);
        tick(6); infravermelho = 1'b0;
        tick(4); chk("pir_fall_hold", int'(motion), 1);
        tick(1); chk("pir_fall_edge", int'(motion), 0);
        tick(5);

        // Setup for 5: button low, motion high.
        push_button = 1'b0; infravermelho = 1'b1; c = cyc;
        push(c + 5, MR, 1'b1, 1'b1);
        push(c + 10, BR, 1'b0, 1'b1);
        tick(15);

        // 5: reset mid-count.
        push_button = 1'b1; tick(5);
        rst = 1'b0; #1;
        chk("midrst_motion", int'(motion), 0);
        chk("midrst_btn_level", int'(btn_level), 0);
        tick(3);
        chk("midrst_hold_motion", int'(motion), 0);
        rst = 1'b1; c = cyc;
        push(c + 5, MR, 1'b0, 1'b1);
        push(c + 10, BP, 1'b1, 1'b1);
        tick(9); chk("restart_full_count", int'(btn_level), 0);
        tick(6);

        // 6: both inputs change together, down then up.
        push_button = 1'b0; infravermelho = 1'b0; c = cyc;
        push(c + 10, BR, 1'b0, 1'b0);
        tick(5); chk("both_down_motion", int'(motion), 0);
        tick(10);
        push_button = 1'b1; infravermelho = 1'b1; c = cyc;
        push(c + 5, MR, 1'b0, 1'b1);
        push(c + 10, BP, 1'b1, 1'b1);
        tick(15);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
